ifm_row_loader: RTL and testbench
=================================

# ifm_row_loader

Streams input-feature-map rows from the DRAM read channel into the four-entry IFM row-buffer ring that feeds `cnn_ctrl`. It writes each row (width × tiled channels words) into the next BRAM buffer and pulses the matching `q_ifm_buf_done` bit when that row is complete. It never overwrites a buffer the controller has not released. It sits directly upstream of `cnn_ctrl`, and its done vector connects straight to `q_ifm_buf_done`.

## Interface
Parameters:
- `W_SIZE`, default 9: width/height/row-counter width (maximum 256).
- `W_CHANNEL`, default 5: tiled-channel count width.
- `IFM_BUF_CNT`, default 4: number of row buffers in the ring.
- `W_IFM_BUF`, default 2: buffer index width.
- `DATA_W`, default 32: DRAM/BRAM word width.
- `BUF_AW`, default 10: per-buffer address width (1024 words).

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `q_start` in 1: frame-start pulse.
- `q_width` in W_SIZE: frame width. Latched at start.
- `q_height` in W_SIZE: frame height. Latched at start.
- `q_channel` in W_CHANNEL: tiled channel count. Latched at start.
- `s_valid` in 1: DRAM read beat valid.
- `s_data` in DATA_W: DRAM read beat.
- `s_ready` out 1: beat accepted when `s_valid & s_ready`.
- `o_buf_we` out IFM_BUF_CNT: one-hot BRAM write strobe.
- `o_buf_addr` out BUF_AW: BRAM write address.
- `o_buf_wdata` out DATA_W: BRAM write data.
- `i_ifm_buf_release` in IFM_BUF_CNT: consumer finished with buffer k (pulse).
- `o_ifm_buf_done` out IFM_BUF_CNT: one-cycle pulse, buffer k holds a complete row.
- `o_row` out W_SIZE: row currently loading.
- `o_busy` out 1: frame in progress.
- `o_load_done` out 1: one-cycle pulse after the last row's done pulse.
- `o_cfg_err` out 1: one-cycle pulse, start rejected.

## Operation
- Row word count: `row_words = width × channel`, computed at W_SIZE+W_CHANNEL bits. Address order: `addr = col*channel + chn`, which is a plain 0..row_words−1 counter.
- Start handling:
  - `q_start` is ignored while `o_busy`.
  - If `row_words > 2^BUF_AW`, start is rejected: `o_cfg_err` pulses and the block stays in IDLE.
  - If any dimension is zero, `o_load_done` pulses and there are no writes.
- Buffer ownership:
  - Each buffer has a `full[k]` flag. It is set when `o_ifm_buf_done[k]` fires and cleared by `i_ifm_buf_release[k]`.
  - Release of a non-full buffer is ignored.
  - If set and release hit the same buffer in the same cycle, set wins.
- Buffer selection: the target buffer index `buf` starts at 0 each frame and advances modulo IFM_BUF_CNT per row.
- FSM states: IDLE, WAIT_BUF, LOAD, ROW_DONE, DONE.
  - IDLE → WAIT_BUF on a valid start. Dimensions are latched, `row` and `buf` are 0, and all `full` flags are cleared.
  - WAIT_BUF → LOAD when `!full[buf]`. The `full` check uses the registered flag, so a release takes effect one cycle later.
  - LOAD: `s_ready=1`. Each accepted beat increments the word counter. The last beat (counter = row_words−1) moves to ROW_DONE.
  - ROW_DONE: `s_ready=0`. `full[buf]` is set. `row` increments and `buf` advances. Next state is DONE if the new row equals height, else WAIT_BUF.
  - DONE: `o_load_done` pulses for 1 cycle, then → IDLE.
- Writes are registered. A beat accepted in cycle t appears on `o_buf_we[buf]`/addr/data in cycle t+1. `o_buf_we` is 0 otherwise.

## Timing
- Reset behaviour:
  - Every output is 0 in the cycle after `rst` is sampled high: `s_ready`, `o_buf_we`, `o_buf_addr`, `o_buf_wdata`, `o_ifm_buf_done`, `o_row`, `o_busy`, `o_load_done`, `o_cfg_err`.
  - The FSM returns to IDLE and all `full` flags clear.
  - Reset mid-row abandons the partial row, with no done pulse.
- Start latency: start sampled in cycle t gives `o_busy=1` and WAIT_BUF in t+1, and `s_ready=1` in t+2 when buffer 0 is free.
- Row completion: last beat accepted in t gives the final write strobe in t+1 (ROW_DONE) and `o_ifm_buf_done[buf]=1` in t+2 only.
- Back-to-back rows: LOAD resumes in t+3 if the next buffer is free, so there are 2 idle `s_ready` cycles between rows.
- Frame end:
  - `o_load_done` is high the cycle after the last done pulse.
  - `o_busy` drops together with `o_load_done`'s fall, i.e. in IDLE.
- Flow control: `s_valid` gaps only stall the word counter. There is no timeout.

## Test plan
1. **Single row.** Width=4, height=1, channel=2, `s_valid` held high, data = beat index. Expect writes at buffer 0, addr 0..7, data 0..7 in consecutive cycles. `o_ifm_buf_done=4'b0001` pulses 2 cycles after the last accept, then `o_load_done` pulses.
2. **Full frame.** Width=256, height=256, channel=4, with the consumer releasing each buffer 10 cycles after its done. Expect 256 done pulses cycling 0001→0010→0100→1000, 1024 writes per row, and a single `o_load_done`.
3. **Backpressure.** Height=6, no releases. Expect done pulses for buffers 0–3, then `s_ready` held at 0 in WAIT_BUF. Releasing buffer 0 restarts LOAD 2 cycles later, writing into buffer 0.
4. **Same-cycle set/release.** Assert `i_ifm_buf_release[1]` in the same cycle `full[1]` is being set. Expect buffer 1 to remain full, and the row-5 load to stall until a later release.
5. **Config edges.** Width=256, channel=8 (2048 > 1024) → `o_cfg_err` pulse, no `o_busy`. Height=0 → `o_load_done` pulse with no writes. `q_start` while busy → no effect.
6. **Reset mid-row.** `rst` asserted after 100 beats of row 2. Expect all outputs 0 the next cycle and no done pulse. A new start begins at row 0, buffer 0.

Source files
------------

// File: rtl/ifm_row_loader.sv
// Loads IFM rows from the DRAM read stream into a ring of BRAM row buffers,
// handing each completed buffer to the controller and waiting for its release.
module ifm_row_loader #(
  parameter int W_SIZE      = 9,
  parameter int W_CHANNEL   = 5,
  parameter int IFM_BUF_CNT = 4,
  parameter int W_IFM_BUF   = 2,
  parameter int DATA_W      = 32,
  parameter int BUF_AW      = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   q_start,
  input  logic [W_SIZE-1:0]      q_width,
  input  logic [W_SIZE-1:0]      q_height,
  input  logic [W_CHANNEL-1:0]   q_channel,
  input  logic                   s_valid,
  input  logic [DATA_W-1:0]      s_data,
  output logic                   s_ready,
  output logic [IFM_BUF_CNT-1:0] o_buf_we,
  output logic [BUF_AW-1:0]      o_buf_addr,
  output logic [DATA_W-1:0]      o_buf_wdata,
  input  logic [IFM_BUF_CNT-1:0] i_ifm_buf_release,
  output logic [IFM_BUF_CNT-1:0] o_ifm_buf_done,
  output logic [W_SIZE-1:0]      o_row,
  output logic                   o_busy,
  output logic                   o_load_done,
  output logic                   o_cfg_err
);

  localparam int W_RW = W_SIZE + W_CHANNEL;
  localparam logic [W_RW-1:0] MAX_WORDS = W_RW'(2 ** BUF_AW);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BUF,
    LOAD,
    ROW_DONE,
    DONE
  } state_t;

  state_t state_reg, state_next;

  logic [W_SIZE-1:0]      height_reg;
  logic [W_SIZE-1:0]      row_reg;
  logic [W_RW-1:0]        last_word_reg;
  logic [BUF_AW-1:0]      word_cnt_reg;
  logic [W_IFM_BUF-1:0]   buf_reg;
  logic [IFM_BUF_CNT-1:0] full_reg, full_next;
  logic [IFM_BUF_CNT-1:0] we_reg;
  logic [BUF_AW-1:0]      addr_reg;
  logic [DATA_W-1:0]      wdata_reg;
  logic [IFM_BUF_CNT-1:0] done_reg;
  logic                   busy_reg;
  logic                   load_done_reg;
  logic                   cfg_err_reg;

  logic [W_RW-1:0]        start_words;
  logic                   start_ok;
  logic                   cfg_bad;
  logic                   dim_zero;
  logic                   frame_start;
  logic                   accept;
  logic                   last_beat;
  logic [IFM_BUF_CNT-1:0] buf_onehot;
  logic [W_IFM_BUF-1:0]   buf_adv;
  logic [W_SIZE-1:0]      row_inc;

  assign start_words = W_RW'(q_width) * W_RW'(q_channel);
  // busy_reg stays high through the load_done cycle, so starts wait until it drops
  assign start_ok    = q_start && (state_reg == IDLE) && !busy_reg;
  assign cfg_bad     = start_words > MAX_WORDS;
  assign dim_zero    = (q_width == '0) || (q_height == '0) || (q_channel == '0);
  assign frame_start = start_ok && !cfg_bad;
  assign accept      = (state_reg == LOAD) && s_valid;
  assign last_beat   = accept && (W_RW'(word_cnt_reg) == last_word_reg);
  assign buf_adv     = (buf_reg == W_IFM_BUF'(IFM_BUF_CNT - 1)) ? '0 : buf_reg + 1'b1;
  assign row_inc     = row_reg + 1'b1;

  // Ownership flags: a completed row's set beats a coincident release.
  for (genvar gi = 0; gi < IFM_BUF_CNT; gi++) begin : g_buf
    assign buf_onehot[gi] = (buf_reg == W_IFM_BUF'(gi));
    assign full_next[gi]  = frame_start ? 1'b0 :
                            ((state_reg == ROW_DONE) && buf_onehot[gi]) ? 1'b1 :
                            i_ifm_buf_release[gi] ? 1'b0 : full_reg[gi];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (frame_start) begin
          state_next = dim_zero ? DONE : WAIT_BUF;
        end
      end
      WAIT_BUF: begin
        if (!full_reg[buf_reg]) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (last_beat) begin
          state_next = ROW_DONE;
        end
      end
      ROW_DONE: begin
        state_next = (row_inc == height_reg) ? DONE : WAIT_BUF;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      height_reg    <= '0;
      row_reg       <= '0;
      last_word_reg <= '0;
      word_cnt_reg  <= '0;
      buf_reg       <= '0;
      full_reg      <= '0;
      we_reg        <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      done_reg      <= '0;
      busy_reg      <= 1'b0;
      load_done_reg <= 1'b0;
      cfg_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      full_reg      <= full_next;
      we_reg        <= '0;
      done_reg      <= '0;
      load_done_reg <= 1'b0;
      cfg_err_reg   <= 1'b0;

      if (load_done_reg) begin
        busy_reg <= 1'b0;
      end

      if (start_ok) begin
        if (cfg_bad) begin
          cfg_err_reg <= 1'b1;
        end else begin
          height_reg    <= q_height;
          last_word_reg <= start_words - W_RW'(1);
          row_reg       <= '0;
          buf_reg       <= '0;
          word_cnt_reg  <= '0;
          busy_reg      <= 1'b1;
        end
      end

      if (accept) begin
        we_reg       <= buf_onehot;
        addr_reg     <= word_cnt_reg;
        wdata_reg    <= s_data;
        word_cnt_reg <= last_beat ? '0 : word_cnt_reg + 1'b1;
      end

      if (state_reg == ROW_DONE) begin
        done_reg <= buf_onehot;
        row_reg  <= row_inc;
        buf_reg  <= buf_adv;
      end

      if (state_reg == DONE) begin
        load_done_reg <= 1'b1;
      end
    end
  end

  assign s_ready        = (state_reg == LOAD);
  assign o_buf_we       = we_reg;
  assign o_buf_addr     = addr_reg;
  assign o_buf_wdata    = wdata_reg;
  assign o_ifm_buf_done = done_reg;
  assign o_row          = row_reg;
  assign o_busy         = busy_reg;
  assign o_load_done    = load_done_reg;
  assign o_cfg_err      = cfg_err_reg;

endmodule

// File: tb/tb_ifm_row_loader.sv
// Randomized bench for ifm_row_loader: a per-cycle row/buffer ownership model
// predicts writes, done pulses, s_ready and frame completion.
module tb_ifm_row_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        q_start = 1'b0;
  logic [8:0]  q_width = '0;
  logic [8:0]  q_height = '0;
  logic [4:0]  q_channel = '0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready;
  logic [3:0]  o_buf_we;
  logic [9:0]  o_buf_addr;
  logic [31:0] o_buf_wdata;
  logic [3:0]  i_ifm_buf_release = '0;
  logic [3:0]  o_ifm_buf_done;
  logic [8:0]  o_row;
  logic        o_busy;
  logic        o_load_done;
  logic        o_cfg_err;

  always #5 clk = ~clk;

  ifm_row_loader dut (
    .clk(clk), .rst(rst), .q_start(q_start), .q_width(q_width), .q_height(q_height),
    .q_channel(q_channel), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .o_buf_we(o_buf_we), .o_buf_addr(o_buf_addr), .o_buf_wdata(o_buf_wdata),
    .i_ifm_buf_release(i_ifm_buf_release), .o_ifm_buf_done(o_ifm_buf_done),
    .o_row(o_row), .o_busy(o_busy), .o_load_done(o_load_done), .o_cfg_err(o_cfg_err)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: frame geometry, beat count and consumer-held buffers
  int rw = 1, total = 0, beats = 0, earliest = 0;
  bit in_frame = 0, loading = 0;
  bit pw_v = 0;
  int pw_buf = 0, pw_addr = 0;
  logic [31:0] pw_data = '0;
  int done_due = -1, done_buf = 0, ld_due = -1, ld_cyc = -100;
  bit ld_flex = 0, cfg_flex = 0;
  int ld_win = 0, cfg_win = 0;
  bit held [4];
  int held_since [4];
  int free_from [4];
  int rel_at [4];
  int done_seen = 0, ld_seen = 0, cfg_seen = 0;

  // Stimulus controls
  int rel_delay = -1, valid_pct = 100;
  bit data_idx = 0;
  logic [3:0] rel_req = '0;
  bit start_req = 0, rst_req = 0;
  int st_w = 0, st_h = 0, st_c = 0;

  task automatic model_clear();
    in_frame = 0; loading = 0; beats = 0; total = 0; pw_v = 0;
    done_due = -1; ld_due = -1; ld_flex = 0; cfg_flex = 0;
    for (int b = 0; b < 4; b++) begin
      held[b] = 0; held_since[b] = 0; free_from[b] = 0; rel_at[b] = -1;
    end
  endtask

  task automatic step();
    logic [3:0] exp_we, exp_done, rel;
    logic exp_rdy, exp_ld, acc;
    logic [31:0] d;
    int tgt, rwn;
    @(negedge clk);
    cyc++;
    exp_we = pw_v ? 4'(1 << pw_buf) : 4'b0000;
    vectors++;
    if (o_buf_we !== exp_we) begin
      miscompares++;
      $display("FAIL write_strobe cyc=%0d got=%b exp=%b", cyc, o_buf_we, exp_we);
    end
    if (pw_v) begin
      vectors++;
      if (o_buf_addr !== 10'(pw_addr) || o_buf_wdata !== pw_data) begin
        miscompares++;
        $display("FAIL write_addr_data cyc=%0d got=%0d/%h exp=%0d/%h",
                 cyc, o_buf_addr, o_buf_wdata, pw_addr, pw_data);
      end
    end
    if (o_ifm_buf_done !== 4'b0000) done_seen++;
    exp_done = (done_due == cyc) ? 4'(1 << done_buf) : 4'b0000;
    vectors++;
    if (o_ifm_buf_done !== exp_done) begin
      miscompares++;
      $display("FAIL buf_done cyc=%0d got=%b exp=%b", cyc, o_ifm_buf_done, exp_done);
    end
    if (done_due == cyc) begin
      held[done_buf] = 1; held_since[done_buf] = cyc; free_from[done_buf] = 32'h7fff_ffff;
      if (rel_delay >= 0) rel_at[done_buf] = cyc + rel_delay;
      if (beats == total) ld_due = cyc + 1;
      done_due = -1;
    end
    if (o_load_done === 1'b1) ld_seen++;
    if (ld_flex) begin
      if (o_load_done === 1'b1) begin
        vectors++; ld_flex = 0; ld_cyc = cyc;
      end else if (cyc > ld_win) begin
        vectors++; miscompares++; ld_flex = 0;
        $display("FAIL load_done_timeout cyc=%0d got=0 exp=1", cyc);
      end
    end else begin
      exp_ld = (ld_due == cyc);
      vectors++;
      if (o_load_done !== exp_ld) begin
        miscompares++;
        $display("FAIL load_done cyc=%0d got=%b exp=%b", cyc, o_load_done, exp_ld);
      end
      if (exp_ld) begin ld_cyc = cyc; in_frame = 0; ld_due = -1; end
    end
    if (o_cfg_err === 1'b1) cfg_seen++;
    if (cfg_flex) begin
      if (o_cfg_err === 1'b1) begin
        vectors++; cfg_flex = 0;
      end else if (cyc > cfg_win) begin
        vectors++; miscompares++; cfg_flex = 0;
        $display("FAIL cfg_err_timeout cyc=%0d got=0 exp=1", cyc);
      end
    end else begin
      vectors++;
      if (o_cfg_err !== 1'b0) begin
        miscompares++;
        $display("FAIL cfg_err cyc=%0d got=%b exp=0", cyc, o_cfg_err);
      end
    end
    if (!ld_flex && cyc != ld_cyc) begin
      vectors++;
      if (o_busy !== logic'(in_frame)) begin
        miscompares++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, o_busy, in_frame);
      end
    end
    tgt = (beats / rw) % 4;
    exp_rdy = in_frame && (beats < total) &&
              (loading || (cyc >= earliest && (!held[tgt] || cyc >= free_from[tgt])));
    vectors++;
    if (s_ready !== exp_rdy) begin
      miscompares++;
      $display("FAIL s_ready cyc=%0d got=%b exp=%b beats=%0d", cyc, s_ready, exp_rdy, beats);
    end
    if (exp_rdy) begin
      loading = 1;
      vectors++;
      if (o_row !== 9'(beats / rw)) begin
        miscompares++;
        $display("FAIL row cyc=%0d got=%0d exp=%0d", cyc, o_row, beats / rw);
      end
    end

    // Drive this cycle's inputs
    rst = rst_req;
    rel = rel_req;
    for (int b = 0; b < 4; b++) begin
      if (rel_at[b] == cyc) begin rel[b] = 1'b1; rel_at[b] = -1; end
      if (rel[b] && held[b] && cyc >= held_since[b] && free_from[b] > cyc + 2)
        free_from[b] = cyc + 2;
    end
    i_ifm_buf_release = rel;
    s_valid = ($urandom_range(99) < valid_pct);
    d = data_idx ? 32'(beats) : $urandom();
    s_data = d;
    acc = s_valid && s_ready && !rst_req;
    pw_v = 0;
    if (acc && in_frame && beats < total) begin
      pw_v = 1; pw_buf = (beats / rw) % 4; pw_addr = beats % rw; pw_data = d;
      beats++;
      if (beats % rw == 0) begin
        loading = 0; earliest = cyc + 3; done_due = cyc + 2; done_buf = pw_buf;
      end
    end
    q_start = start_req;
    q_width = 9'(st_w); q_height = 9'(st_h); q_channel = 5'(st_c);
    if (start_req && !rst_req && !in_frame && !ld_flex && !cfg_flex && cyc != ld_cyc) begin
      rwn = st_w * st_c;
      if (rwn > 1024) begin
        cfg_flex = 1; cfg_win = cyc + 3;
      end else if (st_w == 0 || st_h == 0 || st_c == 0) begin
        ld_flex = 1; ld_win = cyc + 4;
      end else begin
        model_clear();
        in_frame = 1; rw = rwn; total = rwn * st_h; earliest = cyc + 2;
      end
    end
    if (rst_req) model_clear();
    start_req = 0; rst_req = 0; rel_req = '0;
  endtask

  task automatic start(input int w, input int h, input int c);
    start_req = 1; st_w = w; st_h = h; st_c = c;
    step();
  endtask

  task automatic run_until_idle(input int budget, input string name);
    int i;
    i = 0;
    while ((in_frame || ld_flex || cfg_flex || ld_due >= 0) && i < budget) begin
      step();
      i++;
    end
    vectors++;
    if (i >= budget) begin
      miscompares++;
      $display("FAIL %s_timeout cyc=%0d got=busy exp=idle", name, cyc);
    end
    repeat (4) step();
  endtask

  task automatic test_reset();
    rst_req = 1; step(); step();
    vectors++;
    if ({s_ready, o_buf_we, o_buf_addr, o_buf_wdata, o_ifm_buf_done, o_row, o_busy,
         o_load_done, o_cfg_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%b/%b/%0d/%h/%b/%0d/%b exp=all zero",
               s_ready, o_buf_we, o_buf_addr, o_buf_wdata, o_ifm_buf_done, o_row, o_busy);
    end
    repeat (3) step();
    $display("reset: outputs checked");
  endtask

  task automatic test_single_row();
    int d0, l0;
    d0 = done_seen; l0 = ld_seen;
    valid_pct = 100; data_idx = 1; rel_delay = -1;
    start(4, 1, 2);
    step();
    vectors++;
    if (o_busy !== 1'b1 || s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL start_latency busy=%b ready=%b exp busy=1 ready=0", o_busy, s_ready);
    end
    run_until_idle(200, "single_row");
    vectors++;
    if (done_seen - d0 != 1 || ld_seen - l0 != 1) begin
      miscompares++;
      $display("FAIL single_row_pulses got done=%0d ld=%0d exp=1/1", done_seen - d0, ld_seen - l0);
    end
    data_idx = 0;
    $display("single row 4x1x2: done");
  endtask

  task automatic test_full_frame();
    int d0, l0;
    d0 = done_seen; l0 = ld_seen;
    valid_pct = 80; rel_delay = 10;
    start(256, 20, 4);
    run_until_idle(40000, "full_frame");
    vectors++;
    if (done_seen - d0 != 20 || ld_seen - l0 != 1) begin
      miscompares++;
      $display("FAIL full_frame_pulses got done=%0d ld=%0d exp=20/1", done_seen - d0, ld_seen - l0);
    end
    $display("full frame 256x20x4: done");
  endtask

  task automatic test_backpressure();
    int d0, i;
    d0 = done_seen; valid_pct = 100; rel_delay = -1;
    start(5, 6, 3);
    i = 0;
    while (done_seen - d0 < 4 && i < 2000) begin step(); i++; end
    repeat (20) step();
    vectors++;
    if (s_ready !== 1'b0 || beats != 60 || done_seen - d0 != 4) begin
      miscompares++;
      $display("FAIL bp_stall got ready=%b beats=%0d done=%0d exp=0/60/4",
               s_ready, beats, done_seen - d0);
    end
    rel_req = 4'b0001; step();
    step();
    vectors++;
    if (s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release_plus1 got=%b exp=0", s_ready);
    end
    step();
    vectors++;
    if (s_ready !== 1'b1 || o_row !== 9'd4) begin
      miscompares++;
      $display("FAIL bp_release_plus2 got ready=%b row=%0d exp=1/4", s_ready, o_row);
    end
    rel_req = 4'b1110; step();
    run_until_idle(2000, "backpressure");
    vectors++;
    if (done_seen - d0 != 6) begin
      miscompares++;
      $display("FAIL bp_done_count got=%0d exp=6", done_seen - d0);
    end
    $display("backpressure 5x6x3: done");
  endtask

  task automatic test_set_release();
    int d0, i;
    d0 = done_seen; valid_pct = 100; rel_delay = -1;
    start(5, 6, 3);
    i = 0;
    while (done_seen - d0 < 4 && i < 2000) begin
      step(); i++;
      if (done_due == cyc + 2 && done_buf == 1) rel_req = 4'b0010;
    end
    repeat (20) step();
    rel_req = 4'b0001; step();
    i = 0;
    while (done_seen - d0 < 5 && i < 2000) begin step(); i++; end
    repeat (20) step();
    vectors++;
    if (s_ready !== 1'b0 || beats != 75) begin
      miscompares++;
      $display("FAIL setrel_stall got ready=%b beats=%0d exp=0/75", s_ready, beats);
    end
    rel_req = 4'b0010; step();
    run_until_idle(2000, "set_release");
    vectors++;
    if (done_seen - d0 != 6) begin
      miscompares++;
      $display("FAIL setrel_done_count got=%0d exp=6", done_seen - d0);
    end
    $display("same-cycle set/release 5x6x3: done");
  endtask

  task automatic test_config();
    int c0, l0, d0, w0;
    c0 = cfg_seen; l0 = ld_seen;
    start(256, 4, 8); run_until_idle(20, "cfg_2048");
    start(205, 3, 5); run_until_idle(20, "cfg_1025");
    vectors++;
    if (cfg_seen - c0 != 2 || ld_seen != l0) begin
      miscompares++;
      $display("FAIL cfg_err_count got=%0d ld=%0d exp=2/0", cfg_seen - c0, ld_seen - l0);
    end
    l0 = ld_seen;
    start(4, 0, 2); run_until_idle(20, "zero_h");
    start(0, 3, 2); run_until_idle(20, "zero_w");
    start(4, 3, 0); run_until_idle(20, "zero_c");
    vectors++;
    if (ld_seen - l0 != 3) begin
      miscompares++;
      $display("FAIL zero_dim_load_done got=%0d exp=3", ld_seen - l0);
    end
    d0 = done_seen; c0 = cfg_seen; w0 = 0; rel_delay = 0; valid_pct = 70;
    start(6, 3, 2);
    repeat (5) step();
    start(256, 9, 8);
    repeat (7) step();
    start(3, 1, 1);
    run_until_idle(500, "start_busy");
    vectors++;
    if (done_seen - d0 != 3 || cfg_seen != c0) begin
      miscompares++;
      $display("FAIL start_while_busy got done=%0d cfg=%0d exp=3/0", done_seen - d0, cfg_seen - c0);
    end
    $display("config edges: done");
  endtask

  task automatic test_reset_mid_row();
    int d0, i;
    valid_pct = 90; rel_delay = 3;
    start(64, 4, 4);
    i = 0;
    while (beats < 2 * 256 + 100 && i < 5000) begin step(); i++; end
    rst_req = 1; step(); step();
    vectors++;
    if ({s_ready, o_buf_we, o_buf_addr, o_buf_wdata, o_ifm_buf_done, o_row, o_busy,
         o_load_done, o_cfg_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_row got ready=%b we=%b addr=%0d row=%0d busy=%b exp=all zero",
               s_ready, o_buf_we, o_buf_addr, o_row, o_busy);
    end
    d0 = done_seen;
    repeat (10) step();
    vectors++;
    if (done_seen != d0) begin
      miscompares++;
      $display("FAIL reset_no_done got=%0d exp=0", done_seen - d0);
    end
    start(7, 2, 3);
    run_until_idle(500, "after_reset");
    vectors++;
    if (done_seen - d0 != 2) begin
      miscompares++;
      $display("FAIL after_reset_done got=%0d exp=2", done_seen - d0);
    end
    $display("reset mid-row: done");
  endtask

  task automatic test_random();
    int w, h, c, d0;
    for (int k = 0; k < 6; k++) begin
      w = $urandom_range(40, 1); h = $urandom_range(9, 1); c = $urandom_range(6, 1);
      rel_delay = $urandom_range(15); valid_pct = $urandom_range(100, 40);
      d0 = done_seen;
      start(w, h, c);
      run_until_idle(8000, "random");
      vectors++;
      if (done_seen - d0 != h) begin
        miscompares++;
        $display("FAIL random_done_count got=%0d exp=%0d", done_seen - d0, h);
      end
      $display("random frame w=%0d h=%0d c=%0d rel=%0d valid=%0d%%: done", w, h, c, rel_delay, valid_pct);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_row();
    test_full_frame();
    test_backpressure();
    test_set_release();
    test_config();
    test_reset_mid_row();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
